// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
//   Shared definitions for the programmable clock divider controller.
//   state_t : controller states
//     IDLE  - stopped, out_clk low
//     RUN   - dividing
//     PEND  - dividing, new ratio held until the period ends
//     DRAIN - enable dropped, finishing the current period
//   DIV_MIN : smallest legal divide ratio
// ---------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_counter.sv
// ---------------------------------------------------------------------------
// clk_div_counter
//   Period counter for the clock divider. Counts 0 .. cur_div-1 while active
//   and produces registered out_clk / tick aligned with the counter value.
//   Ports:
//     clk, rst_n  source clock, asynchronous active-low reset
//     active      controller is in a counting state this cycle
//     run_next    controller will be in a counting state next cycle
//     cur_div     ratio in effect this cycle (defines the wrap point)
//     div_next    ratio in effect next cycle (defines next out_clk/tick)
//     wrap        last cycle of the current period (combinational)
//     out_clk     divided clock, high floor(div/2), low ceil(div/2) cycles
//     tick        high during the last cycle of each period
// ---------------------------------------------------------------------------
module clk_div_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             run_next,
  input  logic [DIV_W-1:0] cur_div,
  input  logic [DIV_W-1:0] div_next,
  output logic             wrap,
  output logic             out_clk,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;
  logic             out_clk_reg;
  logic             tick_reg;

  assign wrap = active && (cnt_reg == (cur_div - ONE));

  // Counter restarts at 0 on wrap, when leaving IDLE, and whenever stopped.
  always_comb begin
    cnt_next = '0;
    if (run_next && active && !wrap) begin
      cnt_next = cnt_reg + ONE;
    end
  end

  // out_clk/tick are computed from the next counter value and next ratio so
  // the registered outputs always match the registered counter: no runts when
  // the ratio switches at a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      out_clk_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      out_clk_reg <= run_next && (cnt_next < (div_next >> 1));
      tick_reg    <= run_next && (cnt_next == (div_next - ONE));
    end
  end

  assign out_clk = out_clk_reg;
  assign tick    = tick_reg;

endmodule

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//   Run-time programmable, glitch-free integer clock divider controller.
//   Ratio changes and enable/disable only take effect on period boundaries.
//   Ports:
//     clk, rst_n  source clock, asynchronous active-low reset
//     en          1 = run, 0 = stop after the current period
//     cfg_valid   new ratio offered on cfg_div
//     cfg_div     requested ratio (legal 2 .. 2**DIV_W-1)
//     cfg_ready   ratio can be accepted this cycle (IDLE or RUN)
//     cfg_err     one-cycle pulse after an accepted illegal ratio (<2)
//     cur_div     ratio currently in effect
//     out_clk     divided clock, registered
//     tick        one-cycle pulse in the last cycle of each period
//     busy        controller not IDLE
// ---------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             out_clk,
  output logic             tick,
  output logic             busy
);

  localparam logic [DIV_W-1:0] DIV_MIN_W = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);

  state_t           state_reg,   state_next;
  logic [DIV_W-1:0] cur_div_reg, cur_div_next;
  logic [DIV_W-1:0] pend_div_reg, pend_div_next;
  logic             cfg_err_reg, cfg_err_next;

  logic wrap;
  logic xfer;
  logic legal;

  assign cfg_ready = (state_reg == IDLE) || (state_reg == RUN);
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = (cfg_div >= DIV_MIN_W);

  always_comb begin
    state_next    = state_reg;
    cur_div_next  = cur_div_reg;
    pend_div_next = pend_div_reg;
    cfg_err_next  = xfer && !legal;

    case (state_reg)
      IDLE: begin
        if (xfer && legal) cur_div_next = cfg_div;
        if (en) state_next = RUN;
      end

      RUN: begin
        if (xfer && legal && !wrap) begin
          // Mid-period request: hold it and switch at the next wrap.
          pend_div_next = cfg_div;
          state_next    = PEND;
        end else begin
          // On the wrap cycle the new ratio can apply to the next period
          // directly.
          if (xfer && legal) cur_div_next = cfg_div;
          // Enable dropping on the wrap cycle means the current period is
          // already complete, so stop now rather than drain another one.
          if (!en) state_next = wrap ? IDLE : DRAIN;
        end
      end

      PEND: begin
        if (wrap) begin
          cur_div_next = pend_div_reg;
          state_next   = en ? RUN : IDLE;
        end
      end

      DRAIN: begin
        if (en)        state_next = RUN;
        else if (wrap) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cur_div_reg  <= DIV_RST;
      pend_div_reg <= '0;
      cfg_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_div_reg  <= cur_div_next;
      pend_div_reg <= pend_div_next;
      cfg_err_reg  <= cfg_err_next;
    end
  end

  clk_div_counter #(
    .DIV_W (DIV_W)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (state_reg != IDLE),
    .run_next (state_next != IDLE),
    .cur_div  (cur_div_reg),
    .div_next (cur_div_next),
    .wrap     (wrap),
    .out_clk  (out_clk),
    .tick     (tick)
  );

  assign cfg_err = cfg_err_reg;
  assign cur_div = cur_div_reg;
  assign busy    = (state_reg != IDLE);

endmodule
